alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle command front end for the 32-bit combinational ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU's A/B/Op inputs from registers. Shift and rotate commands are turned into repeated single-bit ALU shifts, with the result fed back each cycle. The result and Zero flag come back over a second valid/ready handshake. The block sits between the datapath control and the ALU, acting as the ALU's initiator.

## Interface
- SHAMT_W, 5, width of the shift-count field (max count 2^SHAMT_W-1)
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_func  in  4  ALU op encoding
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_shamt  in  SHAMT_W  iteration count, used by shift/rotate funcs only
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_out  out  32  result
- rsp_zero  out  1  result == 0
- rsp_err  out  1  illegal cmd_func
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_op  out  4  to ALU Op
- alu_out  in  32  from ALU Out
- alu_zero  in  1  from ALU Zero

## Operation
- Func codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 not: single-shot.
  - 1000 sra1, 1010 srl1, 1001 sll1, 1100 rol1, 1101 ror1: iterative.
  - All other codes are illegal.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch: acc<=cmd_a, b_q<=cmd_b, func_q<=cmd_func, cnt<=cmd_shamt.
  - Next state:
    - Illegal func: DONE with rsp_err=1, rsp_out=0, rsp_zero=0.
    - Iterative func with shamt=0: DONE with rsp_out=cmd_a, rsp_zero=~|cmd_a, rsp_err=0.
    - Otherwise: EXEC.
- EXEC, each cycle:
  - Capture acc<=alu_out.
  - Single-shot func, or cnt==1: latch rsp_out<=alu_out, rsp_zero<=alu_zero, rsp_err<=0, go to DONE.
  - Else: cnt<=cnt-1.
- DONE:
  - rsp_valid=1.
  - rsp_out, rsp_zero and rsp_err are held stable until rsp_ready is sampled high, then go to IDLE.
- cmd_ready=0 in EXEC and DONE. There is no overlap between commands.
- alu_a=acc, alu_b=b_q, alu_op=func_q, all straight from registers in every state (glitch-free). ALU output is only consumed in EXEC.
- cmd_b is passed to the ALU unchanged. It is ignored by the ALU for shift/not ops.
- Shift counts are not saturated: rol/ror by 31 is legal. srl/sll by ≥32 is impossible with SHAMT_W=5.

## Timing
- Reset values: cmd_ready=0 while Reset is high, 1 in the first cycle after release. rsp_valid=0, rsp_out=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=0, state=IDLE.
- Accept at the edge ending cycle k:
  - Single-shot: EXEC in cycle k+1, rsp_valid from cycle k+2.
  - Iterative with count n≥1: EXEC in cycles k+1..k+n, rsp_valid from cycle k+n+1.
  - shamt=0 or illegal func: rsp_valid from cycle k+1.
- Response handshake completes at an edge with rsp_valid&rsp_ready. rsp_valid drops and cmd_ready rises the next cycle.
- Minimum period per command is 3 cycles for single-shot, n+2 for iterative.
- cmd_valid while cmd_ready=0 is ignored. The upstream side must hold the command.
- Reset asserted mid-EXEC or mid-DONE forces all outputs to their reset values immediately. The in-flight command is discarded with no response.

## Structure
- Shared header alu_defs.vh holds:
  - localparams for all ten func codes;
  - the legal/iterative decode masks;
  - the FSM state encodings (IDLE=2'd0, EXEC=2'd1, DONE=2'd2).
- The ALU itself is not instantiated inside this block. The connection is made one level up.
- No sub-module. The iteration counter and func decode are small enough to stay inline.

## Test plan
- Add, A=5, B=7, accept in cycle 0 → rsp_valid in cycle 2, rsp_out=0x0000000C, zero=0, err=0.
- Sub, A=B=0x00001234 → rsp_out=0, rsp_zero=1, one EXEC cycle.
- Sra, A=0x80000000, shamt=4 → four EXEC cycles with alu_op=1000 held, rsp_out=0xF8000000, rsp_valid in cycle 5.
- Rol, A=0x12345678, shamt=8 → rsp_out=0x34567812. Ror of that result by 8 returns 0x12345678.
- Edge cases:
  - Sll, A=0, shamt=0 → rsp_out=0, zero=1 in cycle 1.
  - func=0111 → err=1, rsp_out=0 in cycle 1.
- Backpressure and reset:
  - Hold rsp_ready=0 for 3 cycles → rsp_* stable, cmd_ready=0, a new cmd_valid is not accepted.
  - Pulse Reset mid-shift (srl, shamt=20) → all outputs 0 asynchronously, no response.
  - The next command after reset completes normally.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: func codes, decode masks, FSM states.
package alu_sequencer_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FUNC_W      = 4;
    localparam int unsigned SHAMT_W_DEF = 5;

    localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] FUNC_AND = 4'b0010;
    localparam logic [FUNC_W-1:0] FUNC_OR  = 4'b0011;
    localparam logic [FUNC_W-1:0] FUNC_NOT = 4'b0100;
    localparam logic [FUNC_W-1:0] FUNC_SRA = 4'b1000;
    localparam logic [FUNC_W-1:0] FUNC_SLL = 4'b1001;
    localparam logic [FUNC_W-1:0] FUNC_SRL = 4'b1010;
    localparam logic [FUNC_W-1:0] FUNC_ROL = 4'b1100;
    localparam logic [FUNC_W-1:0] FUNC_ROR = 4'b1101;

    // One bit per func code: legal = 0..4, 8, 9, 10, 12, 13; iterative = 8, 9, 10, 12, 13.
    localparam logic [15:0] LEGAL_MASK = 16'h371F;
    localparam logic [15:0] ITER_MASK  = 16'h3700;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        return LEGAL_MASK[f];
    endfunction

    function automatic logic func_iter(input logic [FUNC_W-1:0] f);
        return ITER_MASK[f];
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle command front end for a 32-bit combinational ALU; shifts/rotates are
// executed as repeated single-bit ALU operations with the result fed back.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FUNC_W-1:0]  cmd_func,
    input  logic [DATA_W-1:0]  cmd_a,
    input  logic [DATA_W-1:0]  cmd_b,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_out,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [FUNC_W-1:0]  alu_op,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_zero
);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]    b_q, b_d;
    logic [FUNC_W-1:0]    func_q, func_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]    out_q, out_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            func_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        func_d  = func_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        zero_d  = zero_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    acc_d  = cmd_a;
                    b_d    = cmd_b;
                    func_d = cmd_func;
                    cnt_d  = cmd_shamt;
                    if (!func_legal(cmd_func)) begin
                        state_d = ST_DONE;
                        out_d   = '0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                    end else if (func_iter(cmd_func) && (cmd_shamt == '0)) begin
                        // Zero-count shift completes without touching the ALU.
                        state_d = ST_DONE;
                        out_d   = cmd_a;
                        zero_d  = ~|cmd_a;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                acc_d = alu_out;
                if (!func_iter(func_q) || (cnt_q == SHAMT_W'(1))) begin
                    state_d = ST_DONE;
                    out_d   = alu_out;
                    zero_d  = alu_zero;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - SHAMT_W'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_out   = out_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;
    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_op    = func_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached to its initiator port.
module tb_alu_sequencer;

    logic        Clk;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_func;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [4:0]  cmd_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_zero;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zero;

    typedef struct {
        logic [31:0] out;
        logic        zero;
        logic        err;
        int          vcyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          seen    = 0;
    logic [33:0] held;

    alu_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_func  (cmd_func),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_shamt (cmd_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero)
    );

    // Reference ALU, connected one level above the sequencer
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = ~alu_a;
            4'b1000: alu_out = {alu_a[31], alu_a[31:1]};
            4'b1001: alu_out = {alu_a[30:0], 1'b0};
            4'b1010: alu_out = {1'b0, alu_a[31:1]};
            4'b1100: alu_out = {alu_a[30:0], alu_a[31]};
            4'b1101: alu_out = {alu_a[0], alu_a[31:1]};
            default: alu_out = 32'h0;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on rsp_valid rise, stability while held, payload on handshake
    always @(negedge Clk) begin
        if (Reset) begin
            seen = 0;
        end else begin
            if (rsp_valid && !seen) begin
                seen = 1;
                held = {rsp_out, rsp_zero, rsp_err};
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got out=%h err=%b with nothing pending", rsp_out, rsp_err);
                end else begin
                    check("rsp_latency", 32'(cyc), 32'(sb[0].vcyc));
                end
            end else if (rsp_valid) begin
                check("rsp_stable_out", rsp_out, held[33:2]);
                check("rsp_stable_flags", {30'h0, rsp_zero, rsp_err}, {30'h0, held[1:0]});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_out", rsp_out, e.out);
                    check("rsp_zero", {31'h0, rsp_zero}, {31'h0, e.zero});
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                end
                seen = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] eo, input logic ez,
                         input logic ee, input int lat, input bit expect_rsp);
        int waited = 0;
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_func  = f;
        cmd_a     = a;
        cmd_b     = b;
        cmd_shamt = sh;
        while (!cmd_ready && waited < 200) begin
            @(negedge Clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
            cmd_valid = 1'b0;
            return;
        end
        if (expect_rsp) sb.push_back('{out: eo, zero: ez, err: ee, vcyc: cyc + lat});
        @(posedge Clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb.size() != 0 || !cmd_ready) && waited < 300) begin
            @(negedge Clk);
            waited++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h0);
        check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, "_rsp_out"}, rsp_out, 32'h0);
        check({tag, "_rsp_flags"}, {30'h0, rsp_zero, rsp_err}, 32'h0);
        check({tag, "_alu_a"}, alu_a, 32'h0);
        check({tag, "_alu_b"}, alu_b, 32'h0);
        check({tag, "_alu_op"}, {28'h0, alu_op}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required $finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_func  = 4'h0;
        cmd_a     = 32'h0;
        cmd_b     = 32'h0;
        cmd_shamt = 5'h0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge Clk);
        check_reset_outputs("rst");
        Reset = 1'b0;
        @(negedge Clk);
        check("ready_after_rst", {31'h0, cmd_ready}, 32'h1);

        issue(4'b0000, 32'd5, 32'd7, 5'd0, 32'h0000000C, 1'b0, 1'b0, 2, 1);
        issue(4'b0001, 32'h00001234, 32'h00001234, 5'd0, 32'h0, 1'b1, 1'b0, 2, 1);

        issue(4'b1000, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 1'b0, 1'b0, 5, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("sra_exec_op", {28'h0, alu_op}, 32'h8);
            check("sra_exec_ready", {31'h0, cmd_ready}, 32'h0);
        end

        issue(4'b1100, 32'h12345678, 32'h0, 5'd8, 32'h34567812, 1'b0, 1'b0, 9, 1);
        issue(4'b1101, 32'h34567812, 32'h0, 5'd8, 32'h12345678, 1'b0, 1'b0, 9, 1);
        issue(4'b0010, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd3, 32'h00F0F000, 1'b0, 1'b0, 2, 1);
        issue(4'b0011, 32'hF0000000, 32'h0000000F, 5'd0, 32'hF000000F, 1'b0, 1'b0, 2, 1);
        issue(4'b0100, 32'h0000FFFF, 32'h12345678, 5'd0, 32'hFFFF0000, 1'b0, 1'b0, 2, 1);
        issue(4'b1010, 32'h80000000, 32'h0, 5'd31, 32'h00000001, 1'b0, 1'b0, 32, 1);
        issue(4'b1001, 32'h00000001, 32'h0, 5'd31, 32'h80000000, 1'b0, 1'b0, 32, 1);
        issue(4'b1100, 32'h00000001, 32'h0, 5'd31, 32'h80000000, 1'b0, 1'b0, 32, 1);
        issue(4'b1101, 32'h00000001, 32'h0, 5'd1, 32'h80000000, 1'b0, 1'b0, 2, 1);
        issue(4'b1010, 32'h00000002, 32'h0, 5'd2, 32'h00000000, 1'b1, 1'b0, 3, 1);
        issue(4'b1001, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1, 1);
        issue(4'b1000, 32'hDEADBEEF, 32'h0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1, 1);
        issue(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd3, 32'h0, 1'b0, 1'b1, 1, 1);
        issue(4'b1111, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 1, 1);
        drain();

        // Backpressure: response held while a competing command is presented
        @(posedge Clk);
        #1 rsp_ready = 1'b0;
        issue(4'b0000, 32'd1, 32'd2, 5'd0, 32'h3, 1'b0, 1'b0, 2, 1);
        w = 0;
        while (!rsp_valid && w < 50) begin
            @(negedge Clk);
            w++;
        end
        check("bp_rsp_valid_seen", {31'h0, rsp_valid}, 32'h1);
        cmd_valid = 1'b1;
        cmd_func  = 4'b0000;
        cmd_a     = 32'h55;
        cmd_b     = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            @(negedge Clk);
        end
        @(posedge Clk);
        #1;
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        drain();

        // Reset pulsed mid-shift: outputs clear immediately, no response
        issue(4'b1010, 32'hFFFFFFFF, 32'hA5A5A5A5, 5'd20, 32'h0, 1'b0, 1'b0, 0, 0);
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge Clk);
        Reset = 1'b0;
        repeat (30) @(negedge Clk);
        check("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);

        issue(4'b0000, 32'h10, 32'h20, 5'd0, 32'h30, 1'b0, 1'b0, 2, 1);
        issue(4'b1001, 32'h1, 32'h0, 5'd4, 32'h10, 1'b0, 1'b0, 5, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
